// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: write, read, and scoreboard bus for the multi-port register file.
interface reg_file_mp_if #(
  parameter int DATA_W = 4,
  parameter int DEPTH = 8,
  parameter int NUM_RD = 2,
  localparam int ADDR_W = $clog2(DEPTH)
);
  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     sb_set_en;
  logic [ADDR_W-1:0]        sb_set_addr;
  logic                     any_busy;
  modport master (
    output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    output rd_addr, sb_set_en, sb_set_addr,
    input  rd_data, rd_busy, any_busy
  );
  modport slave (
    input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    input  rd_addr, sb_set_en, sb_set_addr,
    output rd_data, rd_busy, any_busy
  );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: 2-write/N-read register file with write-first forwarding and busy scoreboard.
// Define REG_FILE_MP_ZERO_REG_EN to hardwire register 0 to zero (never busy).
module reg_file_mp #(
  parameter int DATA_W = 4,
  parameter int DEPTH = 8,
  parameter int NUM_RD = 2,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic reset,
  reg_file_mp_if.slave bus
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_nxt [DEPTH];
  logic [DEPTH-1:0] busy, busy_nxt, wr0_hit, wr1_hit, set_hit;
  assign wr0_hit = DEPTH'(bus.wr0_en) << bus.wr0_addr;
  assign wr1_hit = DEPTH'(bus.wr1_en) << bus.wr1_addr;
  assign set_hit = DEPTH'(bus.sb_set_en) << bus.sb_set_addr;
  // Next-state arrays feed both the state registers and the read ports, giving write-first reads.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_nxt[i] = wr1_hit[i] ? bus.wr1_data : wr0_hit[i] ? bus.wr0_data : mem[i];
      busy_nxt[i] = set_hit[i] | (busy[i] & ~(wr0_hit[i] | wr1_hit[i]));
    end
`ifdef REG_FILE_MP_ZERO_REG_EN
    mem_nxt[0] = '0;
    busy_nxt[0] = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
      bus.rd_data <= '0;
      bus.rd_busy <= '0;
      bus.any_busy <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_nxt[i];
      busy <= busy_nxt;
      for (int k = 0; k < NUM_RD; k++) begin
        bus.rd_data[k*DATA_W +: DATA_W] <= mem_nxt[bus.rd_addr[k*ADDR_W +: ADDR_W]];
        bus.rd_busy[k] <= busy_nxt[bus.rd_addr[k*ADDR_W +: ADDR_W]];
      end
      bus.any_busy <= |busy_nxt;
    end
  end
endmodule
